// File: rtl/dm_bus_if.sv
// Bundle of CPU M-stage, DMA and data-memory port signals around the DM arbiter.
// The slave modport is the arbiter's view. The master modport is the view of the requesters and the memory.
interface dm_bus_if;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_byteen;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        dma_req;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic [3:0]  dma_byteen;
  logic        dma_gnt;
  logic [31:0] dma_rdata;
  logic        dma_rvalid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byteen;
  logic [31:0] mem_rdata;
  logic        mem_owner;

  modport slave (
    input  cpu_req, cpu_addr, cpu_wdata, cpu_byteen,
    input  dma_req, dma_addr, dma_wdata, dma_byteen,
    input  mem_rdata,
    output cpu_rdata, cpu_stall, dma_gnt, dma_rdata, dma_rvalid,
    output mem_addr, mem_wdata, mem_byteen, mem_owner
  );

  modport master (
    output cpu_req, cpu_addr, cpu_wdata, cpu_byteen,
    output dma_req, dma_addr, dma_wdata, dma_byteen,
    output mem_rdata,
    input  cpu_rdata, cpu_stall, dma_gnt, dma_rdata, dma_rvalid,
    input  mem_addr, mem_wdata, mem_byteen, mem_owner
  );
endinterface

// File: rtl/dm_bus_arbiter.sv
// Data-memory arbiter: the CPU has fixed priority, and an aging counter forces DMA grants.
// DMA bursts are capped in length, and each burst is followed by one guaranteed CPU slot.
module dm_bus_arbiter #(
  parameter int MAX_WAIT  = 8,
  parameter int BURST_MAX = 4
) (
  input  logic     clk,
  input  logic     reset,
  dm_bus_if.slave  bus
);
  typedef enum logic [1:0] {CPU_PRI, DMA_OWN, COOLDOWN} state_e;

  localparam logic [7:0] MW = 8'(MAX_WAIT);
  localparam logic [3:0] BM = 4'(BURST_MAX);

  state_e      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [3:0]  beat_q, beat_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        cpu_gnt, dma_gnt;
  logic [7:0]  wait_inc;

  assign wait_inc = (wait_q == MW) ? wait_q : wait_q + 8'd1;

  // Grants are held low while reset is asserted, so no beat lands on the reset edge.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    beat_d  = beat_q;
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (!reset) begin
      case (state_q)
        CPU_PRI: begin
          dma_gnt = bus.dma_req && (!bus.cpu_req || wait_q == MW);
          cpu_gnt = bus.cpu_req && !dma_gnt;
          if (dma_gnt) begin
            wait_d  = 8'd0;
            beat_d  = 4'd1;
            state_d = (BM == 4'd1) ? COOLDOWN : DMA_OWN;
          end else if (bus.dma_req) begin
            wait_d = wait_inc;
          end else begin
            wait_d = 8'd0;
          end
        end
        DMA_OWN: begin
          dma_gnt = bus.dma_req;
          if (bus.dma_req) beat_d = beat_q + 4'd1;
          if (!bus.dma_req || beat_q + 4'd1 == BM) state_d = COOLDOWN;
        end
        COOLDOWN: begin
          cpu_gnt = bus.cpu_req;
          if (bus.dma_req) wait_d = wait_inc;
          state_d = CPU_PRI;
        end
        default: state_d = CPU_PRI;
      endcase
    end
  end

  always_comb begin
    rvalid_d = dma_gnt && (bus.dma_byteen == 4'h0);
    rdata_d  = rvalid_d ? bus.mem_rdata : rdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= CPU_PRI;
      wait_q   <= 8'd0;
      beat_q   <= 4'd0;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      beat_q   <= beat_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  // With no grant, the address follows the CPU and the byte enables are zero.
  assign bus.mem_addr   = dma_gnt ? bus.dma_addr  : bus.cpu_addr;
  assign bus.mem_wdata  = dma_gnt ? bus.dma_wdata : bus.cpu_wdata;
  assign bus.mem_byteen = dma_gnt ? bus.dma_byteen : (cpu_gnt ? bus.cpu_byteen : 4'h0);
  assign bus.mem_owner  = dma_gnt;
  assign bus.dma_gnt    = dma_gnt;
  assign bus.cpu_rdata  = cpu_gnt ? bus.mem_rdata : 32'd0;
  assign bus.cpu_stall  = bus.cpu_req && !cpu_gnt && !reset;
  assign bus.dma_rdata  = rdata_q;
  assign bus.dma_rvalid = rvalid_q;
endmodule

// File: tb/tb_dm_bus_arbiter.sv
// Randomized bench for dm_bus_arbiter with a counter-based reference model and a shadow memory.
// Directed phases pin the model with hand-derived literals.
module tb_dm_bus_arbiter;
  localparam int MW = 8;
  localparam int BM = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  dm_bus_if bus();

  dm_bus_arbiter #(.MAX_WAIT(MW), .BURST_MAX(BM)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Physical DM seen by the DUT (64 words)
  logic [31:0] tb_dm [64];
  bit          dm_loaded = 1'b0;
  assign bus.mem_rdata = tb_dm[bus.mem_addr[7:2]];

  always @(posedge clk) begin
    if (!dm_loaded) begin
      for (int i = 0; i < 64; i++) tb_dm[i] <= (i == 8) ? 32'hCAFEF00D : 32'd0;
      dm_loaded <= 1'b1;
    end else begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_byteen[b]) tb_dm[bus.mem_addr[7:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end
  end

  int n_vec = 0;
  int n_err = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: aging count, beats taken in the current ownership (0 = not owning),
  // and a pending guaranteed CPU slot.
  int          m_wait = 0;
  int          m_beats = 0;
  bit          m_cool = 0;
  bit          m_rv = 0;
  logic [31:0] m_rd = 32'd0;
  bit          m_dgnt = 0;
  logic [31:0] s_dm [64];
  bit          s_init = 0;

  always @(negedge clk) begin
    automatic bit cg = 0;
    automatic bit dg = 0;
    automatic logic [3:0]  be;
    automatic logic [31:0] ad, wd;
    automatic int idx;
    if (!s_init) begin
      for (int i = 0; i < 64; i++) s_dm[i] = (i == 8) ? 32'hCAFEF00D : 32'd0;
      s_init = 1;
    end
    if (reset) begin
      m_wait = 0; m_beats = 0; m_cool = 0; m_rv = 0; m_rd = 32'd0;
    end else if (m_cool) begin
      cg = bus.cpu_req;
      if (bus.dma_req && m_wait < MW) m_wait++;
      m_cool = 0;
    end else if (m_beats != 0) begin
      dg = bus.dma_req;
      if (dg) m_beats++;
      if (!bus.dma_req || m_beats == BM) begin m_beats = 0; m_cool = 1; end
    end else begin
      dg = bus.dma_req && (!bus.cpu_req || m_wait == MW);
      cg = bus.cpu_req && !dg;
      if (dg) begin
        m_wait = 0;
        if (BM == 1) m_cool = 1; else m_beats = 1;
      end else if (bus.dma_req) begin
        if (m_wait < MW) m_wait++;
      end else m_wait = 0;
    end
    be  = dg ? bus.dma_byteen : (cg ? bus.cpu_byteen : 4'h0);
    ad  = dg ? bus.dma_addr : bus.cpu_addr;
    wd  = dg ? bus.dma_wdata : bus.cpu_wdata;
    idx = int'(ad[7:2]);
    chk("dma_gnt",    {31'd0, bus.dma_gnt},    {31'd0, dg});
    chk("mem_owner",  {31'd0, bus.mem_owner},  {31'd0, dg});
    chk("cpu_stall",  {31'd0, bus.cpu_stall},  {31'd0, !reset && bus.cpu_req && !cg});
    chk("mem_byteen", {28'd0, bus.mem_byteen}, {28'd0, be});
    chk("mem_addr",   bus.mem_addr, ad);
    chk("mem_wdata",  bus.mem_wdata, wd);
    chk("cpu_rdata",  bus.cpu_rdata, cg ? s_dm[idx] : 32'd0);
    chk("dma_rvalid", {31'd0, bus.dma_rvalid}, {31'd0, m_rv});
    chk("dma_rdata",  bus.dma_rdata, m_rd);
    m_dgnt = dg;
    if (!reset) begin
      if (dg && bus.dma_byteen == 4'h0) begin m_rv = 1; m_rd = s_dm[idx]; end
      else m_rv = 0;
      for (int b = 0; b < 4; b++) if (be[b]) s_dm[idx][8*b +: 8] = wd[8*b +: 8];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.cpu_req = 1'b0;
    bus.dma_req = 1'b0;
    repeat (n) tick();
  endtask

  task automatic new_dma(input logic [5:0] w, input logic [3:0] be);
    bus.dma_addr   = {24'd0, w, 2'b00};
    bus.dma_wdata  = $urandom;
    bus.dma_byteen = be;
  endtask

  initial begin
    int first;
    int left;
    logic [11:0] pat;
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h10; bus.cpu_wdata = 32'hFFFF_FFFF; bus.cpu_byteen = 4'hF;
    bus.dma_req = 1'b1; bus.dma_addr = 32'h40; bus.dma_wdata = 32'hFFFF_FFFF; bus.dma_byteen = 4'hF;
    reset = 1'b1;
    repeat (6) tick();
    reset = 1'b0;
    idle(1);

    // CPU-only store
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h10; bus.cpu_wdata = 32'h12345678; bus.cpu_byteen = 4'hF;
    tick();
    bus.cpu_req = 1'b0;
    chk("dm4_store", tb_dm[4], 32'h12345678);
    idle(2);

    // Contention: CPU loads every cycle, DMA writes held until granted
    first = 0;
    bus.cpu_byteen = 4'h0;
    bus.dma_req = 1'b1;
    new_dma(6'd16, 4'hF);
    for (int k = 1; k <= 30; k++) begin
      bus.cpu_req  = 1'b1;
      bus.cpu_addr = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      tick();
      if (m_dgnt) begin
        if (first == 0) first = k;
        new_dma(6'(16 + (k % 16)), 4'hF);
      end
    end
    chk("first_dma_gnt", first, 32'd9);
    idle(3);

    // Burst cap with the CPU idle: ten DMA beats
    left = 10;
    pat = 12'd0;
    new_dma(6'd48, 4'hF);
    for (int k = 0; k < 12; k++) begin
      bus.dma_req = (left > 0);
      tick();
      pat = {pat[10:0], m_dgnt};
      if (m_dgnt) begin left--; new_dma(6'(48 + k), 4'hF); end
    end
    chk("burst_pat", {20'd0, pat}, {20'd0, 12'b1111_0_1111_0_11});
    chk("burst_beats", left, 32'd0);
    idle(3);

    // DMA read of DM[8]
    bus.dma_req = 1'b1; bus.dma_addr = 32'h20; bus.dma_byteen = 4'h0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (m_dgnt) break;
    end
    bus.dma_req = 1'b0;
    chk("rd_granted", {31'd0, m_dgnt}, 32'd1);
    #6;
    chk("rd_rvalid", {31'd0, bus.dma_rvalid}, 32'd1);
    chk("rd_rdata", bus.dma_rdata, 32'hCAFEF00D);
    idle(3);

    // Reset during beat 2 of a burst
    bus.dma_req = 1'b1; bus.dma_addr = 32'hA0; bus.dma_wdata = 32'h11111111; bus.dma_byteen = 4'hF;
    tick();
    bus.dma_addr = 32'hA4; bus.dma_wdata = 32'h22222222;
    #1 reset = 1'b1;
    #1;
    chk("rst_dma_gnt", {31'd0, bus.dma_gnt}, 32'd0);
    chk("rst_owner",   {31'd0, bus.mem_owner}, 32'd0);
    chk("rst_byteen",  {28'd0, bus.mem_byteen}, 32'd0);
    tick();
    reset = 1'b0;
    bus.dma_req = 1'b0;
    chk("rst_dm40", tb_dm[40], 32'h11111111);
    chk("rst_dm41", tb_dm[41], 32'd0);
    idle(2);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 199) == 0) reset = 1'b1;
      bus.cpu_req    = ($urandom_range(0, 1) == 1);
      bus.cpu_addr   = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      bus.cpu_wdata  = $urandom;
      bus.cpu_byteen = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      if (!(bus.dma_req && !m_dgnt)) begin
        bus.dma_req = ($urandom_range(0, 2) != 0);
        new_dma(6'($urandom_range(0, 63)), ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0);
      end
      tick();
    end
    reset = 1'b0;
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
